// File: rtl/ipm2l_mc_fifo_ctrl.sv
//-----------------------------------------------------------------------------
// ipm2l_mc_fifo_ctrl
//
// Multi-channel synchronous FIFO controller. One external simple-dual-port RAM
// is split into N = 2^c_CH_WIDTH circular FIFOs of D = 2^c_DEPTH_WIDTH words.
// The channel number forms the upper address bits, so each FIFO is confined
// to its own partition. This block only produces addresses, handshakes and
// status; the data path lives in the RAM.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   w_en/w_ch       write request and target channel
//   w_ack, waddr    write accepted (combinational) and RAM write address
//   r_en/r_ch       read request and source channel
//   r_ack, raddr    read accepted (combinational) and RAM read address
//   rd_valid(_ch)   RAM read data valid c_RD_LATENCY cycles after r_ack
//   ch_clr          per-channel synchronous flush
//   wfull, rempty, almost_full, almost_empty   per-channel status flags
//   water_level     per-channel occupancy, (c_DEPTH_WIDTH+1) bits per channel
//
// Optional feature (macro MC_FIFO_ERR_FLAG_EN):
//   err_clr         clears the sticky error flags
//   overflow        sticky: write requested to a full channel
//   underflow       sticky: read requested from an empty channel
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module ipm2l_mc_fifo_ctrl #(
  parameter int c_CH_WIDTH         = 2,
  parameter int c_DEPTH_WIDTH      = 9,
  parameter int c_ALMOST_FULL_NUM  = 508,
  parameter int c_ALMOST_EMPTY_NUM = 4,
  parameter int c_RD_LATENCY       = 1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               w_en,
  input  logic [c_CH_WIDTH-1:0]                              w_ch,
  output logic                                               w_ack,
  output logic [c_CH_WIDTH+c_DEPTH_WIDTH-1:0]                waddr,
  input  logic                                               r_en,
  input  logic [c_CH_WIDTH-1:0]                              r_ch,
  output logic                                               r_ack,
  output logic [c_CH_WIDTH+c_DEPTH_WIDTH-1:0]                raddr,
  output logic                                               rd_valid,
  output logic [c_CH_WIDTH-1:0]                              rd_valid_ch,
  input  logic [(1<<c_CH_WIDTH)-1:0]                         ch_clr,
  output logic [(1<<c_CH_WIDTH)-1:0]                         wfull,
  output logic [(1<<c_CH_WIDTH)-1:0]                         rempty,
  output logic [(1<<c_CH_WIDTH)-1:0]                         almost_full,
  output logic [(1<<c_CH_WIDTH)-1:0]                         almost_empty,
  output logic [(1<<c_CH_WIDTH)*(c_DEPTH_WIDTH+1)-1:0]       water_level
`ifdef MC_FIFO_ERR_FLAG_EN
  ,
  input  logic                                               err_clr,
  output logic [(1<<c_CH_WIDTH)-1:0]                         overflow,
  output logic [(1<<c_CH_WIDTH)-1:0]                         underflow
`endif
);

  localparam int N     = 1 << c_CH_WIDTH;
  localparam int D     = 1 << c_DEPTH_WIDTH;
  localparam int CNT_W = c_DEPTH_WIDTH + 1;
  localparam int LAT   = c_RD_LATENCY;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(D);
  localparam logic [CNT_W-1:0] AF_TH    = CNT_W'(c_ALMOST_FULL_NUM);
  localparam logic [CNT_W-1:0] AE_TH    = CNT_W'(c_ALMOST_EMPTY_NUM);

  // Current pointer values gathered from the per-channel blocks so the
  // address muxes can index them by channel number.
  logic [c_DEPTH_WIDTH-1:0] wptr_cur [N];
  logic [c_DEPTH_WIDTH-1:0] rptr_cur [N];

  // One-hot "this channel is accessed this cycle" decodes of the acks.
  logic [N-1:0] wr_sel;
  logic [N-1:0] rd_sel;

  //---------------------------------------------------------------------------
  // Handshake and address generation
  //---------------------------------------------------------------------------
  // Acceptance looks only at the current count, so a simultaneous read never
  // frees room for a write to a full channel (and vice versa for empty).
  // rst gates the acks so nothing can be accepted while reset is held.
  always_comb begin
    w_ack = ~rst & w_en & ~wfull[w_ch] & ~ch_clr[w_ch];
    r_ack = ~rst & r_en & ~rempty[r_ch] & ~ch_clr[r_ch];
    waddr = {w_ch, wptr_cur[w_ch]};
    raddr = {r_ch, rptr_cur[r_ch]};
  end

  //---------------------------------------------------------------------------
  // Per-channel pointer / count state and flag decode
  //---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic [c_DEPTH_WIDTH-1:0] wptr_q, wptr_d;
      logic [c_DEPTH_WIDTH-1:0] rptr_q, rptr_d;
      logic [CNT_W-1:0]         cnt_q,  cnt_d;

      assign wr_sel[gi] = w_ack & (w_ch == c_CH_WIDTH'(gi));
      assign rd_sel[gi] = r_ack & (r_ch == c_CH_WIDTH'(gi));

      assign wptr_cur[gi] = wptr_q;
      assign rptr_cur[gi] = rptr_q;

      // Pointers wrap naturally at D because they are exactly c_DEPTH_WIDTH
      // bits wide.
      always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (ch_clr[gi]) begin
          // Flush wins; the acks are already blocked for this channel.
          wptr_d = '0;
          rptr_d = '0;
          cnt_d  = '0;
        end else begin
          if (wr_sel[gi]) wptr_d = wptr_q + c_DEPTH_WIDTH'(1);
          if (rd_sel[gi]) rptr_d = rptr_q + c_DEPTH_WIDTH'(1);
          unique case ({wr_sel[gi], rd_sel[gi]})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wptr_q <= '0;
          rptr_q <= '0;
          cnt_q  <= '0;
        end else begin
          wptr_q <= wptr_d;
          rptr_q <= rptr_d;
          cnt_q  <= cnt_d;
        end
      end

      // Flags are decoded straight from the registered count, so reset
      // drives them to their idle values without waiting for a clock.
      assign wfull[gi]        = (cnt_q == FULL_CNT);
      assign rempty[gi]       = (cnt_q == '0);
      assign almost_full[gi]  = (cnt_q >= AF_TH);
      assign almost_empty[gi] = (cnt_q <= AE_TH);
      assign water_level[gi*CNT_W +: CNT_W] = cnt_q;

`ifdef MC_FIFO_ERR_FLAG_EN
      // Sticky error flags. These watch the raw request against the status,
      // so they fire even when the request is rejected for being full/empty.
      // A new event in the same cycle as err_clr keeps the flag set.
      logic ovf_q;
      logic udf_q;
      logic ovf_set;
      logic udf_set;

      assign ovf_set = w_en & (w_ch == c_CH_WIDTH'(gi)) & wfull[gi];
      assign udf_set = r_en & (r_ch == c_CH_WIDTH'(gi)) & rempty[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
          udf_q <= 1'b0;
        end else begin
          if (ovf_set)      ovf_q <= 1'b1;
          else if (err_clr) ovf_q <= 1'b0;
          if (udf_set)      udf_q <= 1'b1;
          else if (err_clr) udf_q <= 1'b0;
        end
      end

      assign overflow[gi]  = ovf_q;
      assign underflow[gi] = udf_q;
`endif
    end
  endgenerate

  //---------------------------------------------------------------------------
  // Read-data-valid pipeline
  //---------------------------------------------------------------------------
  // Matches the RAM read latency. A flush does not touch it: data already
  // requested from the RAM still comes out and is still flagged valid.
  logic                  vld_q [LAT];
  logic [c_CH_WIDTH-1:0] vch_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        vch_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= r_ack;
      vch_q[0] <= r_ch;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        vch_q[i] <= vch_q[i-1];
      end
    end
  end

  assign rd_valid    = vld_q[LAT-1];
  assign rd_valid_ch = vch_q[LAT-1];

endmodule

// File: tb/tb_ipm2l_mc_fifo_ctrl.sv
//-----------------------------------------------------------------------------
// Testbench for ipm2l_mc_fifo_ctrl (default parameters).
// Reference model: one queue of written RAM addresses per channel. Occupancy
// is the queue size, the expected read address is the oldest queued address,
// and the next write address is channel*D + (writes since flush mod D).
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ipm2l_mc_fifo_ctrl;

  localparam int CHW = 2;
  localparam int DW  = 9;
  localparam int N   = 4;
  localparam int D   = 512;
  localparam int CW  = DW + 1;
  localparam int AF  = 508;
  localparam int AE  = 4;
  localparam int LAT = 1;

  logic              clk;
  logic              rst;
  logic              w_en;
  logic [CHW-1:0]    w_ch;
  logic              w_ack;
  logic [CHW+DW-1:0] waddr;
  logic              r_en;
  logic [CHW-1:0]    r_ch;
  logic              r_ack;
  logic [CHW+DW-1:0] raddr;
  logic              rd_valid;
  logic [CHW-1:0]    rd_valid_ch;
  logic [N-1:0]      ch_clr;
  logic [N-1:0]      wfull;
  logic [N-1:0]      rempty;
  logic [N-1:0]      almost_full;
  logic [N-1:0]      almost_empty;
  logic [N*CW-1:0]   water_level;
`ifdef MC_FIFO_ERR_FLAG_EN
  logic              err_clr;
  logic [N-1:0]      overflow;
  logic [N-1:0]      underflow;
`endif

  ipm2l_mc_fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .w_en         (w_en),
    .w_ch         (w_ch),
    .w_ack        (w_ack),
    .waddr        (waddr),
    .r_en         (r_en),
    .r_ch         (r_ch),
    .r_ack        (r_ack),
    .raddr        (raddr),
    .rd_valid     (rd_valid),
    .rd_valid_ch  (rd_valid_ch),
    .ch_clr       (ch_clr),
    .wfull        (wfull),
    .rempty       (rempty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .water_level  (water_level)
`ifdef MC_FIFO_ERR_FLAG_EN
    ,
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int mq [N][$];
  int m_wn [N];
  bit rv_hist[$];
  int rvch_hist[$];
`ifdef MC_FIFO_ERR_FLAG_EN
  bit m_ovf [N];
  bit m_udf [N];
`endif

  // Values sampled just before the clock edge of the last cycle
  logic              s_wack;
  logic              s_rack;
  logic [CHW+DW-1:0] s_waddr;
  logic [CHW+DW-1:0] s_raddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] e_flag(input int kind);
    logic [N-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) begin
      case (kind)
        0:       v[c] = (mq[c].size() == D);
        1:       v[c] = (mq[c].size() == 0);
        2:       v[c] = (mq[c].size() >= AF);
        default: v[c] = (mq[c].size() <= AE);
      endcase
    end
    return v;
  endfunction

  function automatic logic [N*CW-1:0] e_wl();
    logic [N*CW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*CW +: CW] = CW'(mq[c].size());
    return v;
  endfunction

  function automatic int wl(input int c);
    return int'(water_level[c*CW +: CW]);
  endfunction

  task automatic reset_model();
    for (int c = 0; c < N; c++) begin
      mq[c].delete();
      m_wn[c] = 0;
`ifdef MC_FIFO_ERR_FLAG_EN
      m_ovf[c] = 1'b0;
      m_udf[c] = 1'b0;
`endif
    end
    rv_hist.delete();
    rvch_hist.delete();
    for (int i = 0; i < LAT; i++) begin
      rv_hist.push_back(1'b0);
      rvch_hist.push_back(0);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".wfull"},        wfull,        e_flag(0));
    chk({tag, ".rempty"},       rempty,       e_flag(1));
    chk({tag, ".almost_full"},  almost_full,  e_flag(2));
    chk({tag, ".almost_empty"}, almost_empty, e_flag(3));
    chk({tag, ".water_level"},  water_level,  e_wl());
    chk({tag, ".rd_valid"},     rd_valid,     rv_hist[0]);
    if (rv_hist[0]) chk({tag, ".rd_valid_ch"}, rd_valid_ch, rvch_hist[0]);
`ifdef MC_FIFO_ERR_FLAG_EN
    for (int c = 0; c < N; c++) begin
      chk({tag, ".overflow"},  overflow[c],  m_ovf[c]);
      chk({tag, ".underflow"}, underflow[c], m_udf[c]);
    end
`endif
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update the
  // model, check registered state. Entered and left at posedge+1.
  task automatic cycle(input bit we, input int wc, input bit re, input int rc,
                       input logic [N-1:0] clr);
    bit ew;
    bit er;
    w_en   = we;
    w_ch   = wc[CHW-1:0];
    r_en   = re;
    r_ch   = rc[CHW-1:0];
    ch_clr = clr;
    #1;
    ew = we && (mq[wc].size() < D) && !clr[wc];
    er = re && (mq[rc].size() > 0) && !clr[rc];
    s_wack  = w_ack;
    s_rack  = r_ack;
    s_waddr = waddr;
    s_raddr = raddr;
    chk("w_ack", w_ack, ew);
    chk("r_ack", r_ack, er);
    if (ew) chk("waddr", waddr, wc * D + (m_wn[wc] % D));
    if (er) chk("raddr", raddr, mq[rc][0]);
    @(posedge clk);
    #1;
`ifdef MC_FIFO_ERR_FLAG_EN
    for (int c = 0; c < N; c++) begin
      if (we && wc == c && mq[c].size() == D) m_ovf[c] = 1'b1;
      else if (err_clr)                        m_ovf[c] = 1'b0;
      if (re && rc == c && mq[c].size() == 0) m_udf[c] = 1'b1;
      else if (err_clr)                        m_udf[c] = 1'b0;
    end
`endif
    for (int c = 0; c < N; c++) begin
      if (clr[c]) begin
        mq[c].delete();
        m_wn[c] = 0;
      end else begin
        if (ew && wc == c) begin
          mq[c].push_back(c * D + (m_wn[c] % D));
          m_wn[c]++;
        end
        if (er && rc == c) void'(mq[c].pop_front());
      end
    end
    rv_hist.push_back(er);
    rvch_hist.push_back(rc);
    void'(rv_hist.pop_front());
    void'(rvch_hist.pop_front());
    check_state("state");
    $display("t=%0t we=%0d wc=%0d re=%0d rc=%0d clr=%b w_ack=%0d waddr=0x%0h r_ack=%0d raddr=0x%0h rd_valid=%0d",
             $time, we, wc, re, rc, clr, s_wack, s_waddr, s_rack, s_raddr, rd_valid);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    w_en   = 1'b1;
    w_ch   = '0;
    r_en   = 1'b1;
    r_ch   = '0;
    ch_clr = '0;
`ifdef MC_FIFO_ERR_FLAG_EN
    err_clr = 1'b0;
`endif
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.w_ack", w_ack, 1'b0);
    chk("reset.r_ack", r_ack, 1'b0);
    chk("reset.rd_valid_ch", rd_valid_ch, '0);
    check_state("reset");
    w_en = 1'b0;
    r_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit        we;
    int        wc;
    bit        re;
    int        rc;
    logic [3:0] clr;
    bit        e_wack;
    bit        e_rack;
    int        e_waddr;
    int        e_raddr;
    logic [3:0] e_rempty;
    bit        e_rv;
    int        e_rvch;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    //            we wc re rc clr     wack rack waddr  raddr  rempty  rv rvch
    tbl[0] = '{1, 0, 0, 0, 4'b0000, 1, 0, 'h000, 'h000, 4'b1110, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 4'b0000, 1, 1, 'h001, 'h000, 4'b1110, 1, 0};
    tbl[2] = '{1, 1, 1, 1, 4'b0000, 1, 0, 'h200, 'h000, 4'b1100, 0, 0};
    tbl[3] = '{0, 0, 1, 0, 4'b0000, 0, 1, 'h000, 'h001, 4'b1101, 1, 0};
    tbl[4] = '{1, 3, 0, 0, 4'b1000, 0, 0, 'h000, 'h000, 4'b1101, 0, 0};
    tbl[5] = '{1, 2, 0, 0, 4'b0010, 1, 0, 'h400, 'h000, 4'b1011, 0, 0};
    tbl[6] = '{1, 1, 1, 1, 4'b0000, 1, 0, 'h200, 'h000, 4'b1001, 0, 0};
    tbl[7] = '{0, 0, 1, 2, 4'b0000, 0, 1, 'h000, 'h400, 4'b1101, 1, 2};

    do_reset();

    // Table-driven vectors from reset
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].we, tbl[i].wc, tbl[i].re, tbl[i].rc, tbl[i].clr);
      chk("tbl.w_ack", s_wack, tbl[i].e_wack);
      chk("tbl.r_ack", s_rack, tbl[i].e_rack);
      if (tbl[i].e_wack) chk("tbl.waddr", s_waddr, tbl[i].e_waddr);
      if (tbl[i].e_rack) chk("tbl.raddr", s_raddr, tbl[i].e_raddr);
      chk("tbl.rempty", rempty, tbl[i].e_rempty);
      chk("tbl.rd_valid", rd_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk("tbl.rd_valid_ch", rd_valid_ch, tbl[i].e_rvch);
    end

    // Fill ch2 to full
    do_reset();
    for (int i = 0; i < D; i++) begin
      cycle(1, 2, 0, 0, 4'b0000);
      chk("fill.waddr", s_waddr, 'h400 + i);
      if (i == AF - 2) chk("fill.af_below", almost_full[2], 1'b0);
      if (i == AF - 1) chk("fill.af_at", almost_full[2], 1'b1);
    end
    chk("fill.wfull", wfull[2], 1'b1);
    chk("fill.level", wl(2), D);
    cycle(1, 2, 0, 0, 4'b0000);
    chk("fill.reject_w_ack", s_wack, 1'b0);
    chk("fill.others_empty", rempty & 4'b1011, 4'b1011);

    // Drain ch2
    for (int i = 0; i < D; i++) begin
      cycle(0, 0, 1, 2, 4'b0000);
      chk("drain.raddr", s_raddr, 'h400 + i);
      chk("drain.rd_valid", rd_valid, 1'b1);
      chk("drain.rd_valid_ch", rd_valid_ch, 2);
      if (i == D - AE - 2) chk("drain.ae_above", almost_empty[2], 1'b0);
      if (i == D - AE - 1) chk("drain.ae_at", almost_empty[2], 1'b1);
    end
    chk("drain.rempty", rempty[2], 1'b1);

    // Simultaneous write+read on ch1 at count 10, pointers wrap
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 600; i++) begin
      cycle(1, 1, 1, 1, 4'b0000);
      chk("wr_rd.level", wl(1), 10);
    end
    // Empty ch0: write wins, read rejected
    cycle(1, 0, 1, 0, 4'b0000);
    chk("empty_wr_rd.w_ack", s_wack, 1'b1);
    chk("empty_wr_rd.r_ack", s_rack, 1'b0);
    chk("empty_wr_rd.level", wl(0), 1);

    // Flush ch3 at count 100 with a simultaneous write
    for (int i = 0; i < 100; i++) cycle(1, 3, 0, 0, 4'b0000);
    chk("flush.pre_level", wl(3), 100);
    cycle(1, 3, 0, 0, 4'b1000);
    chk("flush.w_ack", s_wack, 1'b0);
    chk("flush.level", wl(3), 0);
    chk("flush.rempty", rempty[3], 1'b1);
    chk("flush.ch0_level", wl(0), 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] clr;
      for (int c = 0; c < N; c++) clr[c] = ($urandom_range(0, 63) == 0);
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, N - 1),
            $urandom_range(0, 99) < 50, $urandom_range(0, N - 1), clr);
    end

    // Asynchronous reset mid-burst: make sure there is a read in flight
    for (int i = 0; i < 8; i++) cycle(1, i % N, 0, 0, 4'b0000);
    cycle(1, 1, 1, 0, 4'b0000);
    chk("areset.pre_rd_valid", rd_valid, 1'b1);
    w_en = 1'b1;
    w_ch = 2'd1;
    r_en = 1'b1;
    r_ch = 2'd2;
    #2;
    rst = 1'b1;
    #1;
    reset_model();
    chk("areset.w_ack", w_ack, 1'b0);
    chk("areset.r_ack", r_ack, 1'b0);
    chk("areset.rd_valid_ch", rd_valid_ch, '0);
    check_state("areset");
    w_en = 1'b0;
    r_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 1, 0, 0, 4'b0000);
    chk("areset.first_waddr", s_waddr, 'h200);

`ifdef MC_FIFO_ERR_FLAG_EN
    for (int i = 0; i < D; i++) cycle(1, 0, 0, 0, 4'b0000);
    cycle(1, 0, 0, 0, 4'b0000);
    chk("err.overflow_set", overflow[0], 1'b1);
    cycle(0, 0, 0, 0, 4'b0000);
    chk("err.overflow_hold", overflow[0], 1'b1);
    err_clr = 1'b1;
    cycle(0, 0, 0, 0, 4'b0000);
    err_clr = 1'b0;
    chk("err.overflow_clr", overflow[0], 1'b0);
    cycle(0, 0, 1, 2, 4'b0000);
    chk("err.underflow_set", underflow[2], 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
